uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised successor to the single-rate serial transmitter. It adds a programmable bit period, optional parity, one or two stop bits, and a small input FIFO, so a producer can queue several words and have them sent back-to-back. It sits between any word-oriented producer and the serial line, and is the standard TX for all new designs.

## Interface

Parameters:
- DATA_WIDTH, 8, data bits per frame (5..9).
- CLKS_PER_BIT, 16, clock cycles per serial bit (>= 1). A value of 1 reproduces the original one-bit-per-clock timing.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, number of stop bits (1 or 2).
- FIFO_DEPTH, 4, input FIFO entries (power of two, >= 2).

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- reset  input  1  asynchronous, active-high reset.
- din  input  DATA_WIDTH  word to transmit; sampled when en && ready.
- en  input  1  write strobe (valid).
- ready  output  1  FIFO not full; a write is accepted on the rising edge where en && ready.
- ser_out  output  1  serial line, registered, idles high.
- busy  output  1  high whenever the FSM is not in IDLE.
- fifo_count  output  $clog2(FIFO_DEPTH+1)  number of words currently stored.

## Operation

- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: ser_out=1. If the FIFO is non-empty, pop the head into the shift register, drive ser_out=0, and go to START.
- START: hold 0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: send DATA_WIDTH bits, LSB first, each held CLKS_PER_BIT cycles.
- After DATA: go to PARITY if PARITY != 0, otherwise go to STOP.
- PARITY: send the parity bit.
  - Odd mode: the parity bit makes the count of ones in data plus parity odd.
  - Even mode: the parity bit makes that count even.
- STOP: hold 1 for STOP_BITS*CLKS_PER_BIT cycles.
- End of the final stop cycle:
  - FIFO non-empty: pop and go straight to START, with no idle gap.
  - FIFO empty: go to IDLE.
- Bit timer: counts 0..CLKS_PER_BIT-1, wraps, and advances the bit index on wrap. Bit index counts 0..DATA_WIDTH-1.
- FIFO pointers wrap modulo FIFO_DEPTH.
- Writes never bypass the FIFO, even when the block is idle and the FIFO is empty.
- Push and pop on the same edge: fifo_count is unchanged and both operations complete.
- ready is derived from the registered count, so a pop on the same edge does not make room for a write while the FIFO is full. A write with ready=0 is dropped with no side effect.
- Reset (asynchronous) aborts any frame and clears the FIFO. Outputs go immediately to:
  - ser_out=1
  - busy=0
  - ready=1
  - fifo_count=0
- After reset release, no residual frame is sent.

## Timing

- Frame length: (1 + DATA_WIDTH + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- Write at edge E into an idle, empty block:
  - fifo_count=1 after E.
  - At E+1 the word is popped: ser_out falls, busy rises, fifo_count=0.
- Bit k (start bit is k=0) occupies edges E+1+k*CLKS_PER_BIT through E+1+(k+1)*CLKS_PER_BIT.
- Back-to-back frames: the start bit of frame n+1 begins on the edge that ends the last stop bit of frame n.
- busy falls on the edge that ends the final stop bit when the FIFO is empty.
- ready falls on the edge that makes fifo_count=FIFO_DEPTH. It rises on the first pop edge after that.
- No combinational path from en/din to any output.

## Test plan

- Reset: assert reset mid-cycle -> ser_out=1, busy=0, ready=1, fifo_count=0 immediately, before the next edge.
- Basic frame, CLKS_PER_BIT=4, PARITY=2, STOP_BITS=1: write 0x55 -> 44-cycle frame, line levels per bit 0,1,0,1,0,1,0,1,0,0(parity),1. Each level is held exactly 4 cycles. busy is high for exactly 44 cycles.
- Parity modes with data 0x07:
  - PARITY=1 -> parity bit 0.
  - PARITY=2 -> parity bit 1.
  - PARITY=0 -> no parity slot, frame is 40 cycles.
  - STOP_BITS=2 -> stop level high for 8 cycles.
- FIFO fill, FIFO_DEPTH=4: assert en for 6 consecutive cycles with 0xA0..0xA5 while idle ->
  - 0xA0..0xA4 accepted.
  - ready=0 after the 5th edge; 0xA5 dropped; fifo_count=4.
  - Five frames are sent contiguously, each start bit immediately following the previous stop bit, in order 0xA0..0xA4.
- Simultaneous push/pop: with fifo_count=2, write on the frame-boundary pop edge -> fifo_count stays 2 and no word is lost or duplicated.
- Reset mid-frame: assert reset during data bit 3 of 0xC3 with 2 words queued -> line high at once and fifo_count=0. After release, no activity until a new write. A new write of 0x3C is then sent correctly.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with programmable bit period, optional parity, 1/2 stop bits
// and an input FIFO that lets a producer queue words for back-to-back frames.
module uart_tx_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [DATA_WIDTH-1:0]              din,
  input  logic                               en,
  output logic                               ready,
  output logic                               ser_out,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_WIDTH + 1);

  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] D_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] S_LAST = BW'(STOP_BITS - 1);
  localparam logic [CW-1:0] FULL   = CW'(FIFO_DEPTH);

  // state    | meaning
  // S_IDLE   | line high, waiting for a queued word
  // S_START  | start bit (low)
  // S_DATA   | data bits, LSB first
  // S_PARITY | parity bit (only when PARITY != 0)
  // S_STOP   | stop bit(s), high
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] head;
  logic                  head_par;
  logic                  push;
  logic                  pop;
  logic                  fifo_empty;
  logic                  bit_end;
  logic                  frame_end;

  state_t                state;
  logic [TW-1:0]         timer;
  logic [BW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_bit;

  // ready comes from the registered count only, so a same-edge pop never frees a slot
  assign ready      = (fifo_count != FULL);
  assign fifo_empty = (fifo_count == '0);
  assign push       = en && ready;
  assign head       = mem[rd_ptr];
  assign head_par   = (PARITY == 1) ? ~(^head) : (^head);

  assign bit_end    = (timer == T_LAST);
  assign frame_end  = (state == S_STOP) && bit_end && (bit_idx == S_LAST);
  assign pop        = !fifo_empty && ((state == S_IDLE) || frame_end);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      ser_out <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          timer   <= '0;
          bit_idx <= '0;
          ser_out <= 1'b1;
          busy    <= 1'b0;
          if (pop) begin
            shreg   <= head;
            par_bit <= head_par;
            ser_out <= 1'b0;
            busy    <= 1'b1;
            state   <= S_START;
          end
        end

        S_START: begin
          if (bit_end) begin
            timer   <= '0;
            bit_idx <= '0;
            ser_out <= shreg[0];
            shreg   <= shreg >> 1;
            state   <= S_DATA;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_DATA: begin
          if (bit_end) begin
            timer <= '0;
            if (bit_idx == D_LAST) begin
              bit_idx <= '0;
              if (PARITY != 0) begin
                ser_out <= par_bit;
                state   <= S_PARITY;
              end else begin
                ser_out <= 1'b1;
                state   <= S_STOP;
              end
            end else begin
              bit_idx <= bit_idx + BW'(1);
              ser_out <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_PARITY: begin
          if (bit_end) begin
            timer   <= '0;
            bit_idx <= '0;
            ser_out <= 1'b1;
            state   <= S_STOP;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_STOP: begin
          if (bit_end) begin
            timer <= '0;
            if (bit_idx == S_LAST) begin
              bit_idx <= '0;
              // a queued word starts its start bit on this very edge, no idle gap
              if (pop) begin
                shreg   <= head;
                par_bit <= head_par;
                ser_out <= 1'b0;
                state   <= S_START;
              end else begin
                ser_out <= 1'b1;
                busy    <= 1'b0;
                state   <= S_IDLE;
              end
            end else begin
              bit_idx <= bit_idx + BW'(1);
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        default: begin
          timer   <= '0;
          bit_idx <= '0;
          ser_out <= 1'b1;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: three instances (even/odd/no parity) share
// stimulus; line levels and busy are checked every cycle against a frame model.
module tb_uart_tx_fifo;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       en;

  logic       ready_e, ser_e, busy_e;
  logic [2:0] cnt_e;
  logic       ready_o, ser_o, busy_o;
  logic [2:0] cnt_o;
  logic       ready_n, ser_n, busy_n;
  logic [2:0] cnt_n;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] words [8];
  int exp_cnt [6] = '{1, 1, 2, 3, 4, 4};
  int exp_rdy [6] = '{1, 1, 1, 1, 0, 0};

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_e (
    .clk(clk), .reset(reset), .din(din), .en(en),
    .ready(ready_e), .ser_out(ser_e), .busy(busy_e), .fifo_count(cnt_e)
  );

  uart_tx_fifo #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_o (
    .clk(clk), .reset(reset), .din(din), .en(en),
    .ready(ready_o), .ser_out(ser_o), .busy(busy_o), .fifo_count(cnt_o)
  );

  uart_tx_fifo #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_n (
    .clk(clk), .reset(reset), .din(din), .en(en),
    .ready(ready_n), .ser_out(ser_n), .busy(busy_n), .fifo_count(cnt_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // frame length in bits: 0 = even parity/1 stop, 1 = odd parity/2 stop, 2 = no parity/1 stop
  function automatic int frame_bits(input int i);
    case (i)
      0:       return 11;
      1:       return 12;
      default: return 10;
    endcase
  endfunction

  function automatic logic exp_level(input int i, input logic [7:0] d, input int k);
    int ones;
    ones = $countones(d);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9) begin
      case (i)
        0:       return ((ones % 2) == 1);
        1:       return ((ones % 2) == 0);
        default: return 1'b1;
      endcase
    end
    return 1'b1;
  endfunction

  function automatic logic ser_of(input int i);
    case (i)
      0:       return ser_e;
      1:       return ser_o;
      default: return ser_n;
    endcase
  endfunction

  function automatic logic busy_of(input int i);
    case (i)
      0:       return busy_e;
      1:       return busy_o;
      default: return busy_n;
    endcase
  endfunction

  // t = 0 is the negedge right after the edge that starts the first frame
  task automatic check_stream(input int n, input int t0, input int inj_t, input logic [7:0] inj_d,
                              input int rdy_t, input string tag);
    int t_end;
    t_end = n * 48 + 4;
    for (int t = t0; t < t_end; t++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        int   fl;
        int   f;
        logic el;
        logic eb;
        fl = frame_bits(i) * CPB;
        f  = t / fl;
        if (f < n) begin
          el = exp_level(i, words[f], (t % fl) / CPB);
          eb = 1'b1;
        end else begin
          el = 1'b1;
          eb = 1'b0;
        end
        chk($sformatf("%s ser[%0d] t=%0d", tag, i, t), {31'd0, ser_of(i)}, {31'd0, el});
        chk($sformatf("%s busy[%0d] t=%0d", tag, i, t), {31'd0, busy_of(i)}, {31'd0, eb});
      end
      if (inj_t >= 0 && t == inj_t - 1) begin
        din = inj_d;
        en  = 1'b1;
      end else if (inj_t >= 0 && t == inj_t) begin
        en = 1'b0;
        chk($sformatf("%s count after push+pop", tag), {29'd0, cnt_e}, 32'd2);
      end
      if (rdy_t >= 0 && t == rdy_t - 1) begin
        chk($sformatf("%s ready while full", tag), {31'd0, ready_e}, 32'd0);
        chk($sformatf("%s count while full", tag), {29'd0, cnt_e}, 32'd4);
      end else if (rdy_t >= 0 && t == rdy_t) begin
        chk($sformatf("%s ready after pop", tag), {31'd0, ready_e}, 32'd1);
        chk($sformatf("%s count after pop", tag), {29'd0, cnt_e}, 32'd3);
      end
    end
  endtask

  initial begin
    int quiet_bad;
    reset = 1'b0;
    en    = 1'b0;
    din   = 8'h00;
    #1 reset = 1'b1;
    #1;
    chk("reset ser", {31'd0, ser_e}, 32'd1);
    chk("reset busy", {31'd0, busy_e}, 32'd0);
    chk("reset ready", {31'd0, ready_e}, 32'd1);
    chk("reset count", {29'd0, cnt_e}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle ser", {31'd0, ser_e}, 32'd1);
    chk("idle busy", {31'd0, busy_e}, 32'd0);

    // basic frame 0x55
    din = 8'h55;
    en  = 1'b1;
    @(negedge clk);
    en = 1'b0;
    chk("0x55 count after write", {29'd0, cnt_e}, 32'd1);
    chk("0x55 busy after write", {31'd0, busy_e}, 32'd0);
    chk("0x55 ser after write", {31'd0, ser_e}, 32'd1);
    @(negedge clk);
    chk("0x55 start ser", {31'd0, ser_e}, 32'd0);
    chk("0x55 start busy", {31'd0, busy_e}, 32'd1);
    chk("0x55 count after pop", {29'd0, cnt_e}, 32'd0);
    words[0] = 8'h55;
    check_stream(1, 1, -1, 8'h00, -1, "frame55");

    // parity modes and two stop bits with 0x07
    din = 8'h07;
    en  = 1'b1;
    @(negedge clk);
    en = 1'b0;
    words[0] = 8'h07;
    check_stream(1, 0, -1, 8'h00, -1, "frame07");

    // FIFO fill: six consecutive writes, sixth dropped
    din = 8'hA0;
    en  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("fill count edge %0d", i + 1), {29'd0, cnt_e}, exp_cnt[i]);
      chk($sformatf("fill ready edge %0d", i + 1), {31'd0, ready_e}, exp_rdy[i]);
      if (i < 5) din = 8'hA1 + 8'(i);
      else en = 1'b0;
    end
    words[0] = 8'hA0;
    words[1] = 8'hA1;
    words[2] = 8'hA2;
    words[3] = 8'hA3;
    words[4] = 8'hA4;
    check_stream(5, 5, -1, 8'h00, 44, "fill");

    // simultaneous push and pop at the frame boundary
    din = 8'h11;
    en  = 1'b1;
    @(negedge clk);
    din = 8'h22;
    @(negedge clk);
    din = 8'h33;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("pushpop count before", {29'd0, cnt_e}, 32'd2);
    words[0] = 8'h11;
    words[1] = 8'h22;
    words[2] = 8'h33;
    words[3] = 8'h44;
    check_stream(4, 3, 44, 8'h44, -1, "pushpop");

    // reset in data bit 3 of 0xC3 with two words queued
    din = 8'hC3;
    en  = 1'b1;
    @(negedge clk);
    din = 8'hAA;
    @(negedge clk);
    din = 8'hBB;
    @(negedge clk);
    en = 1'b0;
    chk("midreset queued", {29'd0, cnt_e}, 32'd2);
    repeat (16) @(negedge clk);
    chk("midreset data bit3", {31'd0, ser_e}, 32'd0);
    chk("midreset busy before", {31'd0, busy_e}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("midreset ser", {31'd0, ser_e}, 32'd1);
    chk("midreset busy", {31'd0, busy_e}, 32'd0);
    chk("midreset ready", {31'd0, ready_e}, 32'd1);
    chk("midreset count", {29'd0, cnt_e}, 32'd0);
    chk("midreset ser odd", {31'd0, ser_o}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    quiet_bad = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (ser_e !== 1'b1 || busy_e !== 1'b0 || cnt_e !== 3'd0 ||
          ser_o !== 1'b1 || ser_n !== 1'b1) quiet_bad++;
    end
    chk("quiet after reset", quiet_bad, 32'd0);
    din = 8'h3C;
    en  = 1'b1;
    @(negedge clk);
    en = 1'b0;
    chk("0x3C count after write", {29'd0, cnt_e}, 32'd1);
    words[0] = 8'h3C;
    check_stream(1, 0, -1, 8'h00, -1, "frame3C");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
